control_id: RTL and testbench
=============================

CONTROL_ID -- requirements
Module: control_id

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- Instr  input  32  IF/ID instruction: opcode [31:26], rs [25:21], rt [20:16].
- SaltoTomado  input  1  one-cycle pulse: conditional branch resolved taken in EX.
- Control  output  10  registered control word to the ID/EX control register.
- PCWrite  output  1  combinational PC enable.
- IFIDWrite  output  1  combinational IF/ID enable.
- IFIDFlush  output  1  combinational IF/ID clear.
- Ilegal  output  1  registered unknown-opcode flag.
- CuentaBurbujas  output  16  registered bubble count.

REQ-002 Control bit map SHALL be:
- [9] Saltoincond
- [8] RegDest
- [7] FuenteALU
- [6] MemaReg
- [5] EscrReg
- [4] LeerMem
- [3] EscrMem
- [2] SaltoCond
- [1:0] ALUOp

Function
REQ-003 The decode table SHALL be:
- R-type 000000 -> 10'h122
- lw 100011 -> 10'h0F0
- sw 101011 -> 10'h088
- beq 000100 -> 10'h005
- j 000010 -> 10'h200
- addi 001000 -> 10'h0A0
- any other opcode -> 10'h000, with Ilegal=1 for the following cycle.

REQ-004 Control SHALL update only on the rising edge of clk, one cycle after Instr is presented; this is the block's latency.

REQ-005 A bubble SHALL be Control=10'h000 with Ilegal=0; every bubble SHALL increment CuentaBurbujas, saturating at 16'hFFFF.

REQ-006 The FSM SHALL have states NORMAL, TRAS_CARGA (lw just issued; holds its rt in LwRt) and TRAS_SALTO (j just issued).

REQ-007 Per-cycle priority SHALL be:
1. SaltoTomado
2. TRAS_SALTO
3. load-use hazard
4. normal decode

REQ-008 SaltoTomado=1, in any state:
- IFIDFlush=1, PCWrite=1, IFIDWrite=1.
- Next Control is a bubble.
- Next state is NORMAL; any pending load-use is discarded.

REQ-009 In TRAS_SALTO (without SaltoTomado):
- Instr is discarded and next Control is a bubble.
- PCWrite=1, IFIDWrite=1, IFIDFlush=0.
- Next state is NORMAL.

REQ-010 A load-use hazard SHALL exist when all of the following hold:
- state is TRAS_CARGA;
- LwRt is not 0;
- either LwRt equals rs, or LwRt equals rt and the opcode is R-type, sw or beq.

REQ-011 On a load-use hazard:
- PCWrite=0, IFIDWrite=0, IFIDFlush=0.
- Next Control is a bubble.
- Next state is NORMAL, so exactly one bubble is inserted per lw and the held instruction decodes on the following cycle.

REQ-012 On normal decode:
- PCWrite=1, IFIDWrite=1, IFIDFlush=0, and the decoded word is registered.
- Next state is TRAS_CARGA with LwRt<=rt for lw, TRAS_SALTO for j, otherwise NORMAL.

REQ-013 An illegal opcode SHALL NOT set Ilegal when it is suppressed by REQ-008, REQ-009 or REQ-011.

REQ-014 Back-to-back lw instructions SHALL each re-enter TRAS_CARGA with the newest rt.

Reset
REQ-015 While reset=1:
- Control=10'h000, Ilegal=0, CuentaBurbujas=0, state=NORMAL, LwRt=0.
- PCWrite=0, IFIDWrite=0, IFIDFlush=0.

REQ-016 Assertion of reset mid-stall or mid-flush SHALL abort that operation immediately.

REQ-017 The first edge after reset deassertion SHALL perform a normal decode.

Structure
REQ-018 Package control_pkg SHALL hold:
- opcode constants;
- Control bit-index constants;
- the six control-word constants;
- the FSM state enum.

REQ-019 Sub-module control_decode SHALL be purely combinational: opcode in, 10-bit word and illegal flag out.

REQ-020 The FSM, LwRt, counter and output registers SHALL reside in control_id.

Verification
REQ-021 Reset then R-type 0x012A4020 -> after one edge Control=10'h122; PCWrite=1.

REQ-022 lw 0x8C080004 (rt=8) followed by add with rs=8 (0x01095020):
- hazard cycle: PCWrite=0, IFIDWrite=0;
- Control=10'h000, then 10'h122;
- CuentaBurbujas=1.

REQ-023 j 0x08000010 then any addi -> Control=10'h200, then 10'h000; the addi is never issued.

REQ-024 SaltoTomado=1 asserted in the same cycle as a load-use hazard:
- IFIDFlush=1, PCWrite=1;
- Control=10'h000;
- no second bubble follows.

REQ-025 Opcode 111111 -> Control=10'h000 and Ilegal=1 for exactly one cycle.

REQ-026 With CuentaBurbujas preloaded to 16'hFFFF, a further bubble leaves it at 16'hFFFF.

REQ-027 Asserting reset during a stall -> all outputs return to their REQ-015 values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/control_pkg.sv
// control_pkg: opcodes, control-word layout and FSM states shared by the ID control unit
package control_pkg;
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam int CB_SALTOINCOND = 9;
    localparam int CB_REGDEST     = 8;
    localparam int CB_FUENTEALU   = 7;
    localparam int CB_MEMAREG     = 6;
    localparam int CB_ESCRREG     = 5;
    localparam int CB_LEERMEM     = 4;
    localparam int CB_ESCRMEM     = 3;
    localparam int CB_SALTOCOND   = 2;
    localparam int CB_ALUOP_HI    = 1;
    localparam int CB_ALUOP_LO    = 0;
    localparam logic [9:0] CW_R    = 10'h122;
    localparam logic [9:0] CW_LW   = 10'h0F0;
    localparam logic [9:0] CW_SW   = 10'h088;
    localparam logic [9:0] CW_BEQ  = 10'h005;
    localparam logic [9:0] CW_J    = 10'h200;
    localparam logic [9:0] CW_ADDI = 10'h0A0;
    localparam logic [9:0] CW_NOP  = 10'h000;
    typedef enum logic [1:0] {NORMAL, TRAS_CARGA, TRAS_SALTO} state_t;
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode to control-word lookup with unknown-opcode flag
module control_decode
    import control_pkg::*;
(
    input  logic [5:0] op,
    output logic [9:0] word,
    output logic       illegal
);
    always_comb begin
        word = op == OP_R    ? CW_R    :
               op == OP_LW   ? CW_LW   :
               op == OP_SW   ? CW_SW   :
               op == OP_BEQ  ? CW_BEQ  :
               op == OP_J    ? CW_J    :
               op == OP_ADDI ? CW_ADDI : CW_NOP;
        illegal = !(op == OP_R || op == OP_LW || op == OP_SW ||
                    op == OP_BEQ || op == OP_J || op == OP_ADDI);
    end
endmodule

// File: rtl/control_id.sv
// control_id: ID-stage control with load-use stall, jump squash, branch flush and bubble counter
module control_id
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        SaltoTomado,
    output logic [9:0]  Control,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        Ilegal,
    output logic [15:0] CuentaBurbujas
);
    state_t      state_q, state_d;
    logic [4:0]  lw_rt_q, lw_rt_d;
    logic [9:0]  control_q, control_d;
    logic        ilegal_q, ilegal_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [9:0]  dec_word;
    logic        dec_illegal, uses_rt, hazard, bubble, unused_bits;

    assign op = Instr[31:26];
    assign rs = Instr[25:21];
    assign rt = Instr[20:16];
    assign unused_bits = ^Instr[15:0];

    control_decode u_decode (.op(op), .word(dec_word), .illegal(dec_illegal));

    always_comb begin
        uses_rt = op == OP_R || op == OP_SW || op == OP_BEQ;
        hazard = state_q == TRAS_CARGA && lw_rt_q != 5'd0 &&
                 (lw_rt_q == rs || (lw_rt_q == rt && uses_rt));
        bubble = SaltoTomado || state_q == TRAS_SALTO || hazard;
        control_d = bubble ? CW_NOP : dec_word;
        ilegal_d = !bubble && dec_illegal;
        state_d = bubble ? NORMAL : op == OP_LW ? TRAS_CARGA : op == OP_J ? TRAS_SALTO : NORMAL;
        lw_rt_d = (!bubble && op == OP_LW) ? rt : lw_rt_q;
        cnt_d = (bubble && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        PCWrite = !reset && !(hazard && !SaltoTomado);
        IFIDWrite = PCWrite;
        IFIDFlush = !reset && SaltoTomado;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= NORMAL;
            lw_rt_q   <= 5'd0;
            control_q <= CW_NOP;
            ilegal_q  <= 1'b0;
            cnt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            lw_rt_q   <= lw_rt_d;
            control_q <= control_d;
            ilegal_q  <= ilegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign Control        = control_q;
    assign Ilegal         = ilegal_q;
    assign CuentaBurbujas = cnt_q;
endmodule

// File: tb/tb_control_id.sv
// tb_control_id: randomized scoreboard bench for control_id against an issue-history reference model
module tb_control_id;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instr = 32'h012A4020;
    logic        SaltoTomado = 1'b0;
    logic [9:0]  Control;
    logic        PCWrite, IFIDWrite, IFIDFlush, Ilegal;
    logic [15:0] CuentaBurbujas;

    control_id dut (
        .clk(clk), .reset(reset), .Instr(Instr), .SaltoTomado(SaltoTomado),
        .Control(Control), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IFIDFlush(IFIDFlush), .Ilegal(Ilegal), .CuentaBurbujas(CuentaBurbujas)
    );

    always #5 clk = ~clk;

    typedef struct {logic pc; logic ifw; logic fl;} comb_t;
    typedef struct {logic [9:0] ctl; logic ilg; logic [15:0] cnt;} reg_t;
    comb_t comb_q[$];
    reg_t  reg_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    logic       last_valid;
    logic [5:0] last_op;
    logic [4:0] last_rt;
    int         cnt;
    logic       stalled;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] ref_dec(input logic [5:0] op);
        case (op)
            6'h00: return {1'b0, 10'h122};
            6'h23: return {1'b0, 10'h0F0};
            6'h2B: return {1'b0, 10'h088};
            6'h04: return {1'b0, 10'h005};
            6'h02: return {1'b0, 10'h200};
            6'h08: return {1'b0, 10'h0A0};
            default: return {1'b1, 10'h000};
        endcase
    endfunction

    task automatic model_reset();
        last_valid = 1'b0;
        last_op = 6'h00;
        last_rt = 5'd0;
        cnt = 0;
        stalled = 1'b0;
        comb_q.delete();
        reg_q.delete();
    endtask

    // model reasons about the instruction actually issued on the previous cycle
    task automatic drive(input logic [31:0] ins, input logic st);
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic [10:0] d;
        logic dep, after_j, bub;
        comb_t c;
        reg_t r;
        @(posedge clk);
        #2;
        Instr = ins;
        SaltoTomado = st;
        op = ins[31:26];
        rs = ins[25:21];
        rt = ins[20:16];
        d = ref_dec(op);
        after_j = last_valid && last_op == 6'h02;
        dep = last_valid && last_op == 6'h23 && last_rt != 5'd0 &&
              (last_rt == rs || (last_rt == rt && (op == 6'h00 || op == 6'h2B || op == 6'h04)));
        bub = st || after_j || dep;
        c.pc = !(dep && !st);
        c.ifw = c.pc;
        c.fl = st;
        if (bub && cnt < 65535) cnt++;
        r.ctl = bub ? 10'h000 : d[9:0];
        r.ilg = !bub && d[10];
        r.cnt = cnt[15:0];
        stalled = dep && !st;
        last_valid = !bub;
        last_op = op;
        last_rt = rt;
        comb_q.push_back(c);
        reg_q.push_back(r);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        case ($urandom_range(0, 7))
            0: op = 6'h00;
            1: op = 6'h23;
            2: op = 6'h2B;
            3: op = 6'h04;
            4: op = 6'h02;
            5: op = 6'h08;
            6: op = 6'h3F;
            default: op = 6'($urandom_range(0, 63));
        endcase
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
    endfunction

    initial forever begin
        comb_t c;
        @(negedge clk);
        if (comb_q.size() != 0) begin
            c = comb_q.pop_front();
            check("pcwrite", 32'(PCWrite), 32'(c.pc));
            check("ifidwrite", 32'(IFIDWrite), 32'(c.ifw));
            check("ifidflush", 32'(IFIDFlush), 32'(c.fl));
        end
    end

    initial forever begin
        reg_t r;
        @(posedge clk);
        #1;
        if (reg_q.size() != 0) begin
            r = reg_q.pop_front();
            check("control", 32'(Control), 32'(r.ctl));
            check("ilegal", 32'(Ilegal), 32'(r.ilg));
            check("cuenta", 32'(CuentaBurbujas), 32'(r.cnt));
        end
    end

    initial begin
        logic [31:0] ins;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_control", 32'(Control), 32'h0);
        check("rst_ilegal", 32'(Ilegal), 32'h0);
        check("rst_cuenta", 32'(CuentaBurbujas), 32'h0);
        check("rst_pcwrite", 32'(PCWrite), 32'h0);
        check("rst_ifidwrite", 32'(IFIDWrite), 32'h0);
        check("rst_ifidflush", 32'(IFIDFlush), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(32'h012A4020, 1'b0);
        drive(32'h8C080004, 1'b0);
        check("first_decode", 32'(Control), 32'h122);
        drive(32'h01095020, 1'b0);
        #1;
        check("lu_pcwrite", 32'(PCWrite), 32'h0);
        check("lu_ifidwrite", 32'(IFIDWrite), 32'h0);
        drive(32'h01095020, 1'b0);
        check("lu_bubble", 32'(Control), 32'h0);
        check("lu_count", 32'(CuentaBurbujas), 32'h1);
        drive(32'h08000010, 1'b0);
        check("lu_resume", 32'(Control), 32'h122);
        drive(32'h20010005, 1'b0);
        check("j_issue", 32'(Control), 32'h200);
        drive(32'h8C080004, 1'b0);
        check("j_squash", 32'(Control), 32'h0);
        drive(32'h01095020, 1'b1);
        #1;
        check("flush_ifidflush", 32'(IFIDFlush), 32'h1);
        check("flush_pcwrite", 32'(PCWrite), 32'h1);
        drive(32'h01095020, 1'b0);
        check("flush_bubble", 32'(Control), 32'h0);
        drive(32'hFC000000, 1'b0);
        check("flush_no_second", 32'(Control), 32'h122);
        drive(32'h012A4020, 1'b0);
        check("ill_control", 32'(Control), 32'h0);
        check("ill_flag", 32'(Ilegal), 32'h1);
        drive(32'h8C080004, 1'b0);
        check("ill_one_cycle", 32'(Ilegal), 32'h0);
        drive(32'h01095020, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_control", 32'(Control), 32'h0);
        check("async_pcwrite", 32'(PCWrite), 32'h0);
        check("async_ifidwrite", 32'(IFIDWrite), 32'h0);
        check("async_cuenta", 32'(CuentaBurbujas), 32'h0);
        check("async_ilegal", 32'(Ilegal), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ins = rand_instr();
        for (int i = 0; i < 600; i++) begin
            drive(ins, $urandom_range(0, 7) == 0);
            if (!stalled) ins = rand_instr();
        end
        for (int i = 0; i < 65600; i++) drive(rand_instr(), 1'b1);
        drive(32'h012A4020, 1'b0);
        @(posedge clk);
        #3;
        check("sat_cuenta", 32'(CuentaBurbujas), 32'hFFFF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
